// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder_if
// Description : Job control, slice-FIFO read side and array-edge bundle for
//               the systolic skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if #(
    parameter int ROWS = 16,
    parameter int K_W  = 12
);
    logic                 start;
    logic [K_W-1:0]       k_len;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic [ROWS-1:0]      fifo_empty;
    logic [ROWS-1:0]      fifo_rd_en;
    logic [ROWS*8-1:0]    fifo_dout;
    logic [ROWS*8-1:0]    arr_data;
    logic [ROWS-1:0]      arr_valid;

    // Feeder side
    modport slave (
        input  start, k_len, fifo_empty, fifo_dout,
        output busy, done, cfg_err, fifo_rd_en, arr_data, arr_valid
    );

    // Job issuer / FIFO / array side
    modport master (
        output start, k_len, fifo_empty, fifo_dout,
        input  busy, done, cfg_err, fifo_rd_en, arr_data, arr_valid
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Reads per-row byte FIFOs in diagonal order and drives the
//               west edge of the systolic array with stall-aligned operands.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int ROWS = 16,
    parameter int K_W  = 12
) (
    input  wire logic               clk,
    input  wire logic               srst,
    systolic_skew_feeder_if.slave   bus
);

    localparam int             T_W       = K_W + 1;
    localparam logic [T_W-1:0] C_ROWS_M2 = T_W'(ROWS - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t              r_state;
    logic [T_W-1:0]      r_t;
    logic [K_W-1:0]      r_k_len;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;
    logic [ROWS*8-1:0]   r_arr_data;
    logic [ROWS-1:0]     r_arr_valid;

    logic [ROWS-1:0]     w_active;
    logic [ROWS-1:0]     w_rd_en;
    logic                w_run;
    logic                w_stall;
    logic                w_k_legal;
    logic [T_W-1:0]      w_t_end;
    logic                w_last_step;

    // Row i is live for k_len steps starting at step i; the extra bit keeps
    // i + k_len from wrapping for large jobs.
    genvar g_i;
    generate
        for (g_i = 0; g_i < ROWS; g_i = g_i + 1) begin : g_row_active
            assign w_active[g_i] = (r_t >= T_W'(g_i)) &&
                                   (r_t <  ({1'b0, r_k_len} + T_W'(g_i)));
        end
    endgenerate

    assign w_run       = (r_state == S_RUN);
    assign w_stall     = w_run && (|(w_active & bus.fifo_empty));
    assign w_rd_en     = (w_run && !w_stall) ? w_active : '0;
    assign w_k_legal   = (bus.k_len != '0) && (bus.k_len[2:0] == 3'd0);
    assign w_t_end     = {1'b0, r_k_len} + C_ROWS_M2;
    assign w_last_step = (r_t == w_t_end);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_k_len   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_k_legal) begin
                            r_k_len <= bus.k_len;
                            r_t     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A stall freezes the whole wavefront so the skew holds.
                    if (!w_stall) begin
                        if (w_last_step) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_LAST;
                        end else begin
                            r_t <= r_t + T_W'(1);
                        end
                    end
                end
                S_LAST: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_arr_data  <= '0;
            r_arr_valid <= '0;
        end else begin
            r_arr_valid <= w_rd_en;
            for (int i = 0; i < ROWS; i++) begin
                r_arr_data[8*i +: 8] <= w_rd_en[i] ? bus.fifo_dout[8*i +: 8] : 8'h00;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.arr_data   = r_arr_data;
    assign bus.arr_valid  = r_arr_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_skew_feeder
// Description : Scoreboard bench for the skew feeder with a byte-FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int K_W  = 12;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.ROWS(ROWS), .K_W(K_W)) bus ();
    systolic_skew_feeder #(.ROWS(ROWS), .K_W(K_W)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q [ROWS][$];
    int          exp_done[$];
    int          exp_cfg[$];

    logic [7:0]  mem [ROWS][512];
    int          rptr [ROWS];
    int          wptr [ROWS];
    int          rd_total [ROWS];
    int          rd_base [ROWS];
    logic [ROWS-1:0] force_empty;
    logic [ROWS-1:0] pend;

    int cyc = 0;
    int nchk;
    int nfail;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            bus.fifo_empty[i]       = (rptr[i] == wptr[i]) || force_empty[i];
            bus.fifo_dout[8*i +: 8] = mem[i][rptr[i][8:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte FIFO model: reads sampled just before the edge, retired at negedge.
    task automatic fifo_model();
        forever begin
            @(negedge clk);
            for (int i = 0; i < ROWS; i++) begin
                if (srst) begin
                    rptr[i] = wptr[i];
                end else if (pend[i]) begin
                    if (rptr[i] < wptr[i]) rptr[i]++;
                    rd_total[i]++;
                end
            end
            #4;
            pend = srst ? '0 : bus.fifo_rd_en;
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            for (int i = 0; i < ROWS; i++) begin
                if (bus.arr_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("row%0d_extra_valid", i), 1, 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("row%0d_valid_cycle", i), cyc, e.cyc);
                        chk($sformatf("row%0d_data", i), bus.arr_data[8*i +: 8], e.data);
                    end
                end else if (bus.arr_data[8*i +: 8] !== 8'h00) begin
                    chk($sformatf("row%0d_idle_data", i), bus.arr_data[8*i +: 8], 0);
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) chk("extra_done", 1, 0);
                else begin
                    c = exp_done.pop_front();
                    chk("done_cycle", cyc, c);
                end
            end
            if (bus.cfg_err) begin
                if (exp_cfg.size() == 0) chk("extra_cfg_err", 1, 0);
                else begin
                    c = exp_cfg.pop_front();
                    chk("cfg_err_cycle", cyc, c);
                end
            end
        end
    endtask

    task automatic prefill(input int k, input logic [7:0] base);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < k; j++) begin
                mem[i][wptr[i][8:0]] = base + 8'(j);
                wptr[i]++;
            end
        end
    endtask

    // Hand timing: row i reads at step i+j; steps at/after a stall shift by its length.
    task automatic push_exp(input int k, input logic [7:0] base, input int rs,
                            input int st_at, input int st_len);
        exp_t e;
        int   s;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < k; j++) begin
                s      = i + j;
                e.cyc  = rs + s + ((st_len > 0 && s >= st_at) ? st_len : 0) + 1;
                e.data = base + 8'(j);
                exp_q[i].push_back(e);
            end
        end
        exp_done.push_back(rs + k + ROWS - 2 + st_len + 1);
    endtask

    task automatic start_job(input int k, output int rs);
        bus.k_len = K_W'(k);
        bus.start = 1'b1;
        tick(1);
        rs        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic snap_reads();
        for (int i = 0; i < ROWS; i++) rd_base[i] = rd_total[i];
    endtask

    task automatic chk_reads(input string name, input int n);
        for (int i = 0; i < ROWS; i++)
            chk($sformatf("%s_row%0d", name, i), rd_total[i] - rd_base[i], n);
    endtask

    task automatic flush_from(input int c);
        for (int i = 0; i < ROWS; i++)
            while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].cyc >= c)
                void'(exp_q[i].pop_back());
        while (exp_done.size() > 0 && exp_done[exp_done.size()-1] >= c)
            void'(exp_done.pop_back());
    endtask

    initial begin
        int rs;
        int rs1;
        srst        = 1'b1;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        force_empty = '0;
        pend        = '0;
        nchk        = 0;
        nfail       = 0;
        for (int i = 0; i < ROWS; i++) begin
            rptr[i] = 0; wptr[i] = 0; rd_total[i] = 0; rd_base[i] = 0;
        end
        fork
            fifo_model();
            monitor();
        join_none

        // Reset state
        tick(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_arr_valid", bus.arr_valid, 0);
        chk("rst_arr_data", bus.arr_data, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        srst = 1'b0;
        tick(2);

        // Nominal job, k_len=8
        prefill(8, 8'h00);
        snap_reads();
        start_job(8, rs);
        push_exp(8, 8'h00, rs, 0, 0);
        chk("busy_run_entry", bus.busy, 1);
        tick(10);
        chk("busy_last_step", bus.busy, 1);
        tick(1);
        chk("busy_in_done_cycle", bus.busy, 0);
        tick(1);
        chk("busy_after_done", bus.busy, 0);
        chk_reads("nominal_reads", 8);
        tick(2);

        // Row 2 empty for 3 cycles at t=4
        prefill(8, 8'h10);
        snap_reads();
        start_job(8, rs);
        push_exp(8, 8'h10, rs, 4, 3);
        tick(4);
        force_empty[2] = 1'b1;
        tick(1);
        chk("stall_rd_en", bus.fifo_rd_en, 0);
        tick(2);
        force_empty[2] = 1'b0;
        tick(9);
        chk_reads("stall_reads", 8);

        // Illegal k_len
        bus.k_len = K_W'(12);
        bus.start = 1'b1;
        tick(1);
        exp_cfg.push_back(cyc);
        bus.start = 1'b0;
        chk("cfg12_busy", bus.busy, 0);
        chk("cfg12_rd_en", bus.fifo_rd_en, 0);
        tick(1);
        chk("cfg12_busy_after", bus.busy, 0);
        bus.k_len = '0;
        bus.start = 1'b1;
        tick(1);
        exp_cfg.push_back(cyc);
        bus.start = 1'b0;
        chk("cfg0_busy", bus.busy, 0);
        tick(1);
        chk("cfg0_rd_en", bus.fifo_rd_en, 0);
        tick(2);

        // start held during RUN is ignored
        prefill(8, 8'h20);
        snap_reads();
        start_job(8, rs);
        push_exp(8, 8'h20, rs, 0, 0);
        tick(3);
        bus.start = 1'b1;
        tick(4);
        bus.start = 1'b0;
        tick(6);
        chk_reads("start_in_run_reads", 8);
        chk("start_in_run_idle_busy", bus.busy, 0);

        // srst at t=5 aborts the job
        prefill(8, 8'h30);
        start_job(8, rs);
        push_exp(8, 8'h30, rs, 0, 0);
        tick(5);
        #1 srst = 1'b1;
        flush_from(cyc);
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_arr_valid", bus.arr_valid, 0);
        chk("abort_rd_en", bus.fifo_rd_en, 0);
        chk("abort_done", bus.done, 0);
        tick(2);
        srst = 1'b0;
        tick(1);
        prefill(8, 8'h40);
        snap_reads();
        start_job(8, rs);
        push_exp(8, 8'h40, rs, 0, 0);
        tick(12);
        chk_reads("post_abort_reads", 8);

        // Back-to-back jobs, start held high
        prefill(16, 8'h50);
        prefill(8, 8'h80);
        snap_reads();
        bus.k_len = K_W'(16);
        bus.start = 1'b1;
        tick(1);
        rs1 = cyc;
        push_exp(16, 8'h50, rs1, 0, 0);
        bus.k_len = K_W'(8);
        tick(20);
        chk_reads("b2b_first_reads", 16);
        chk("b2b_gap_rd_en", bus.fifo_rd_en, 0);
        tick(1);
        push_exp(8, 8'h80, rs1 + 21, 0, 0);
        bus.start = 1'b0;
        tick(12);
        chk_reads("b2b_total_reads", 24);

        tick(4);
        for (int i = 0; i < ROWS; i++)
            chk($sformatf("row%0d_missing_valids", i), exp_q[i].size(), 0);
        chk("missing_done", exp_done.size(), 0);
        chk("missing_cfg_err", exp_cfg.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
